// File: rtl/aha_ahb_code_arbiter.sv
// Two-port AHB-lite arbiter for the code region: DCODE (S0) wins by default,
// ICODE (S1) is guaranteed a slot after MAX_WAIT consecutive losses.
module aha_ahb_code_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  HTRANS_S0,
  input  logic [31:0] HADDR_S0,
  input  logic [2:0]  HSIZE_S0,
  input  logic        HWRITE_S0,
  input  logic [31:0] HWDATA_S0,
  output logic        HREADY_S0,
  output logic [1:0]  HRESP_S0,
  output logic [31:0] HRDATA_S0,
  input  logic [1:0]  HTRANS_S1,
  input  logic [31:0] HADDR_S1,
  input  logic [2:0]  HSIZE_S1,
  input  logic        HWRITE_S1,
  input  logic [31:0] HWDATA_S1,
  output logic        HREADY_S1,
  output logic [1:0]  HRESP_S1,
  output logic [31:0] HRDATA_S1,
  output logic        HSEL_M,
  output logic [1:0]  HTRANS_M,
  output logic [31:0] HADDR_M,
  output logic [2:0]  HSIZE_M,
  output logic        HWRITE_M,
  output logic [31:0] HWDATA_M,
  output logic        HREADY_M,
  input  logic        HREADYOUT_M,
  input  logic [1:0]  HRESP_M,
  input  logic [31:0] HRDATA_M
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_S0   = 2'd1,
    OWN_S1   = 2'd2
  } owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  owner_t      owner;
  owner_t      grant;
  logic        hold0_vld, hold1_vld;
  logic [31:0] hold0_addr, hold1_addr;
  logic [2:0]  hold0_size, hold1_size;
  logic        hold0_write, hold1_write;
  logic [3:0]  wait_cnt;
  logic        bus_free;
  logic        ready0, ready1;
  logic        live0, live1;
  logic        req1;
  logic        unused_trans;

  // Only the NONSEQ/SEQ bit matters; every issued transfer is re-typed NONSEQ.
  assign unused_trans = HTRANS_S0[0] ^ HTRANS_S1[0];

  assign HREADY_M = (owner != OWN_NONE) ? HREADYOUT_M : 1'b1;
  assign bus_free = HREADY_M;

  assign ready0 = hold0_vld ? 1'b0 : ((owner == OWN_S0) ? HREADYOUT_M : 1'b1);
  assign ready1 = hold1_vld ? 1'b0 : ((owner == OWN_S1) ? HREADYOUT_M : 1'b1);
  assign HREADY_S0 = ready0;
  assign HREADY_S1 = ready1;

  assign live0 = HTRANS_S0[1] & ready0;
  assign live1 = HTRANS_S1[1] & ready1;
  assign req1  = hold1_vld | live1;

  always_comb begin
    grant = OWN_NONE;
    if (HRESETn && bus_free) begin
      if (req1 && (wait_cnt == WAIT_MAX)) grant = OWN_S1;
      else if (hold0_vld)                 grant = OWN_S0;
      else if (live0)                     grant = OWN_S0;
      else if (hold1_vld)                 grant = OWN_S1;
      else if (live1)                     grant = OWN_S1;
    end
  end

  // Address phase toward the slave: parked phase takes precedence over the live bus.
  always_comb begin
    HSEL_M   = 1'b0;
    HTRANS_M = 2'b00;
    HADDR_M  = '0;
    HSIZE_M  = '0;
    HWRITE_M = 1'b0;
    case (grant)
      OWN_S0: begin
        HSEL_M   = 1'b1;
        HTRANS_M = 2'b10;
        HADDR_M  = hold0_vld ? hold0_addr  : HADDR_S0;
        HSIZE_M  = hold0_vld ? hold0_size  : HSIZE_S0;
        HWRITE_M = hold0_vld ? hold0_write : HWRITE_S0;
      end
      OWN_S1: begin
        HSEL_M   = 1'b1;
        HTRANS_M = 2'b10;
        HADDR_M  = hold1_vld ? hold1_addr  : HADDR_S1;
        HSIZE_M  = hold1_vld ? hold1_size  : HSIZE_S1;
        HWRITE_M = hold1_vld ? hold1_write : HWRITE_S1;
      end
      default: ;
    endcase
  end

  always_comb begin
    HWDATA_M = '0;
    case (owner)
      OWN_S0:  HWDATA_M = HWDATA_S0;
      OWN_S1:  HWDATA_M = HWDATA_S1;
      default: ;
    endcase
  end

  assign HRESP_S0  = (owner == OWN_S0) ? HRESP_M  : 2'b00;
  assign HRDATA_S0 = (owner == OWN_S0) ? HRDATA_M : 32'd0;
  assign HRESP_S1  = (owner == OWN_S1) ? HRESP_M  : 2'b00;
  assign HRDATA_S1 = (owner == OWN_S1) ? HRDATA_M : 32'd0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner    <= OWN_NONE;
      wait_cnt <= 4'd0;
    end else begin
      if (bus_free) owner <= grant;
      if (grant == OWN_S1) begin
        wait_cnt <= 4'd0;
      end else if ((grant == OWN_S0) && req1 && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end
  end

  // A live phase that was accepted by the master but lost arbitration is parked here.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold0_vld   <= 1'b0;
      hold0_addr  <= '0;
      hold0_size  <= '0;
      hold0_write <= 1'b0;
    end else if (grant == OWN_S0) begin
      hold0_vld   <= 1'b0;
      hold0_addr  <= '0;
      hold0_size  <= '0;
      hold0_write <= 1'b0;
    end else if (live0) begin
      hold0_vld   <= 1'b1;
      hold0_addr  <= HADDR_S0;
      hold0_size  <= HSIZE_S0;
      hold0_write <= HWRITE_S0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold1_vld   <= 1'b0;
      hold1_addr  <= '0;
      hold1_size  <= '0;
      hold1_write <= 1'b0;
    end else if (grant == OWN_S1) begin
      hold1_vld   <= 1'b0;
      hold1_addr  <= '0;
      hold1_size  <= '0;
      hold1_write <= 1'b0;
    end else if (live1) begin
      hold1_vld   <= 1'b1;
      hold1_addr  <= HADDR_S1;
      hold1_size  <= HSIZE_S1;
      hold1_write <= HWRITE_S1;
    end
  end

endmodule

// File: tb/tb_aha_ahb_code_arbiter.sv
// Bench for aha_ahb_code_arbiter: directed scenarios then randomized traffic,
// every cycle compared against a port-level behavioural model.
module tb_aha_ahb_code_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  trans [2];
  logic [31:0] addr  [2];
  logic [2:0]  size  [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic        hready_s [2];
  logic [1:0]  hresp_s  [2];
  logic [31:0] hrdata_s [2];
  logic        hsel_m;
  logic [1:0]  htrans_m;
  logic [31:0] haddr_m;
  logic [2:0]  hsize_m;
  logic        hwrite_m;
  logic [31:0] hwdata_m;
  logic        hready_m;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  int checks = 0;
  int failures = 0;
  string phase = "init";

  always #5 clk = ~clk;

  aha_ahb_code_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .HTRANS_S0(trans[0]), .HADDR_S0(addr[0]), .HSIZE_S0(size[0]),
    .HWRITE_S0(wr[0]), .HWDATA_S0(wdata[0]),
    .HREADY_S0(hready_s[0]), .HRESP_S0(hresp_s[0]), .HRDATA_S0(hrdata_s[0]),
    .HTRANS_S1(trans[1]), .HADDR_S1(addr[1]), .HSIZE_S1(size[1]),
    .HWRITE_S1(wr[1]), .HWDATA_S1(wdata[1]),
    .HREADY_S1(hready_s[1]), .HRESP_S1(hresp_s[1]), .HRDATA_S1(hrdata_s[1]),
    .HSEL_M(hsel_m), .HTRANS_M(htrans_m), .HADDR_M(haddr_m), .HSIZE_M(hsize_m),
    .HWRITE_M(hwrite_m), .HWDATA_M(hwdata_m), .HREADY_M(hready_m),
    .HREADYOUT_M(hreadyout), .HRESP_M(hresp), .HRDATA_M(hrdata)
  );

  // Model state: data-phase owner (-1 none), parked phases, S1 loss streak.
  int          own;
  bit          pend  [2];
  logic [31:0] p_addr[2];
  logic [2:0]  p_size[2];
  logic        p_wr  [2];
  int          lost;
  bit          e_rdy [2];
  bit          e_live[2];
  bit          e_want1;
  bit          e_free;
  int          e_win;
  bit          held  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = -1;
    lost = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      p_addr[p] = '0;
      p_size[p] = '0;
      p_wr[p] = 1'b0;
    end
  endtask

  task automatic model_eval();
    bit want [2];
    e_free = (own < 0) ? 1'b1 : bit'(hreadyout);
    for (int p = 0; p < 2; p++) begin
      e_rdy[p]  = pend[p] ? 1'b0 : ((own == p) ? bit'(hreadyout) : 1'b1);
      e_live[p] = bit'(trans[p][1]) && e_rdy[p];
      want[p]   = pend[p] || e_live[p];
    end
    e_want1 = want[1];
    e_win = -1;
    // S0 has priority unless S1 has already lost MAX_WAIT times in a row.
    if (rst_n && e_free) begin
      if (want[1] && lost >= MAX_WAIT) e_win = 1;
      else if (want[0])                e_win = 0;
      else if (want[1])                e_win = 1;
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (e_win == 1) lost = 0;
    else if (e_win == 0 && e_want1 && lost < MAX_WAIT) lost = lost + 1;
    for (int p = 0; p < 2; p++) begin
      if (e_win == p) begin
        pend[p] = 1'b0;
      end else if (e_live[p]) begin
        pend[p] = 1'b1;
        p_addr[p] = addr[p];
        p_size[p] = size[p];
        p_wr[p] = wr[p];
      end
    end
    if (e_free) own = e_win;
  endtask

  task automatic compare_all();
    logic [31:0] ea;
    logic [2:0]  es;
    logic        ew;
    ea = '0; es = '0; ew = 1'b0;
    if (e_win >= 0) begin
      ea = pend[e_win] ? p_addr[e_win] : addr[e_win];
      es = pend[e_win] ? p_size[e_win] : size[e_win];
      ew = pend[e_win] ? p_wr[e_win]   : wr[e_win];
    end
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s HREADY_S%0d", phase, p), 32'(hready_s[p]), 32'(e_rdy[p]));
      check($sformatf("%s HRESP_S%0d", phase, p), 32'(hresp_s[p]), (own == p) ? 32'(hresp) : 32'd0);
      check($sformatf("%s HRDATA_S%0d", phase, p), hrdata_s[p], (own == p) ? hrdata : 32'd0);
    end
    check({phase, " HSEL_M"},   32'(hsel_m),   32'(e_win >= 0));
    check({phase, " HTRANS_M"}, 32'(htrans_m), (e_win >= 0) ? 32'd2 : 32'd0);
    check({phase, " HADDR_M"},  haddr_m,       ea);
    check({phase, " HSIZE_M"},  32'(hsize_m),  32'(es));
    check({phase, " HWRITE_M"}, 32'(hwrite_m), 32'(ew));
    check({phase, " HWDATA_M"}, hwdata_m,      (own >= 0) ? wdata[own] : 32'd0);
    check({phase, " HREADY_M"}, 32'(hready_m), 32'(e_free));
  endtask

  task automatic settle();
    #1;
    model_eval();
    compare_all();
  endtask

  task automatic advance();
    @(posedge clk);
    for (int p = 0; p < 2; p++) held[p] = rst_n && !e_rdy[p];
    model_commit();
    @(negedge clk);
  endtask

  task automatic drv(input int p, input logic [1:0] t, input logic [31:0] a,
                     input logic w, input logic [31:0] d);
    trans[p] = t;
    addr[p]  = a;
    size[p]  = 3'b010;
    wr[p]    = w;
    wdata[p] = d;
  endtask

  task automatic slv(input logic rdy, input logic [1:0] rsp, input logic [31:0] rd);
    hreadyout = rdy;
    hresp     = rsp;
    hrdata    = rd;
  endtask

  task automatic rand_masters();
    int r;
    for (int p = 0; p < 2; p++) begin
      if (!held[p]) begin
        r = $urandom_range(0, 9);
        trans[p] = (r < 4) ? 2'b00 : (r < 6) ? 2'b10 : (r < 9) ? 2'b11 : 2'b01;
        addr[p]  = $urandom & 32'h0000_fffc;
        size[p]  = 3'($urandom_range(0, 2));
        wr[p]    = 1'($urandom_range(0, 1));
        wdata[p] = $urandom;
      end
    end
  endtask

  initial begin
    int a0;
    int a1;
    rst_n = 1'b0;
    drv(0, 2'b00, 0, 0, 0);
    drv(1, 2'b00, 0, 0, 0);
    slv(1'b1, 2'b00, 32'h0);
    model_reset();
    held[0] = 1'b0;
    held[1] = 1'b0;

    phase = "reset";
    @(negedge clk);
    settle();
    check("reset HREADY_S0", 32'(hready_s[0]), 32'd1);
    check("reset HREADY_S1", 32'(hready_s[1]), 32'd1);
    check("reset HSEL_M", 32'(hsel_m), 32'd0);
    check("reset HREADY_M", 32'(hready_m), 32'd1);
    advance();
    rst_n = 1'b1;

    phase = "uncontested";
    drv(0, 2'b10, 32'h0000_0100, 1'b0, 0);
    settle();
    check("uncontested issue HSEL_M", 32'(hsel_m), 32'd1);
    check("uncontested issue HADDR_M", haddr_m, 32'h0000_0100);
    check("uncontested HREADY_S0", 32'(hready_s[0]), 32'd1);
    check("uncontested HREADY_S1", 32'(hready_s[1]), 32'd1);
    advance();
    drv(0, 2'b00, 0, 0, 0);
    slv(1'b1, 2'b00, 32'h1234_5678);
    settle();
    check("uncontested HRDATA_S0", hrdata_s[0], 32'h1234_5678);
    check("uncontested data HREADY_S0", 32'(hready_s[0]), 32'd1);
    check("uncontested HRDATA_S1", hrdata_s[1], 32'd0);
    advance();

    phase = "collision";
    drv(0, 2'b10, 32'h10, 1'b0, 0);
    drv(1, 2'b10, 32'h20, 1'b0, 0);
    slv(1'b1, 2'b00, 32'h0);
    settle();
    check("collision winner HADDR_M", haddr_m, 32'h10);
    advance();
    drv(0, 2'b00, 0, 0, 0);
    drv(1, 2'b00, 0, 0, 0);
    slv(1'b1, 2'b00, 32'hAAAA_0010);
    settle();
    check("collision loser HREADY_S1", 32'(hready_s[1]), 32'd0);
    check("collision replay HADDR_M", haddr_m, 32'h20);
    check("collision replay HTRANS_M", 32'(htrans_m), 32'd2);
    check("collision HRDATA_S0", hrdata_s[0], 32'hAAAA_0010);
    check("collision HRDATA_S1 quiet", hrdata_s[1], 32'd0);
    advance();
    slv(1'b1, 2'b00, 32'hBBBB_0020);
    settle();
    check("collision HRDATA_S1", hrdata_s[1], 32'hBBBB_0020);
    check("collision HRDATA_S0 quiet", hrdata_s[0], 32'd0);
    check("collision HREADY_S1 back", 32'(hready_s[1]), 32'd1);
    advance();

    phase = "pending_write";
    drv(0, 2'b10, 32'h80, 1'b0, 0);
    drv(1, 2'b10, 32'h40, 1'b1, 0);
    slv(1'b1, 2'b00, 32'h0);
    settle();
    advance();
    for (int k = 0; k < 4; k++) begin
      drv(0, 2'b00, 0, 0, 0);
      drv(1, 2'b00, 0, 0, 32'hDEAD_BEEF);
      slv(k == 3, 2'b00, 32'h0);
      settle();
      check($sformatf("pending_write HREADY_S1 k%0d", k), 32'(hready_s[1]), 32'd0);
      if (k < 3) check($sformatf("pending_write stall HSEL_M k%0d", k), 32'(hsel_m), 32'd0);
      advance();
    end
    settle();
    check("pending_write HWDATA_M", hwdata_m, 32'hDEAD_BEEF);
    check("pending_write data HREADY_S1", 32'(hready_s[1]), 32'd1);
    advance();
    drv(1, 2'b00, 0, 0, 0);

    phase = "starvation";
    a0 = 32'h1000;
    a1 = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      drv(0, 2'b10, 32'(a0), 1'b0, 0);
      drv(1, 2'b10, 32'(a1), 1'b0, 0);
      slv(1'b1, 2'b00, $urandom);
      settle();
      if (i < 4) check($sformatf("starvation S0 wins i%0d", i), haddr_m, 32'(32'h1000 + 4 * i));
      if (i == 4) check("starvation S1 forced", haddr_m, 32'h2000);
      if (i == 5) check("starvation S0 resumes", haddr_m, 32'h1010);
      if (e_rdy[0]) a0 = a0 + 4;
      if (e_rdy[1]) a1 = a1 + 4;
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, 2'b00, 0, 0, 0);
      drv(1, 2'b00, 0, 0, 0);
      slv(1'b1, 2'b00, $urandom);
      settle();
      advance();
    end

    phase = "error";
    drv(0, 2'b10, 32'h300, 1'b0, 0);
    drv(1, 2'b10, 32'h400, 1'b0, 0);
    slv(1'b1, 2'b00, 32'h0);
    settle();
    check("error S0 issue HADDR_M", haddr_m, 32'h300);
    advance();
    drv(0, 2'b00, 0, 0, 0);
    drv(1, 2'b00, 0, 0, 0);
    slv(1'b0, 2'b01, 32'h0);
    settle();
    check("error c1 HRESP_S0", 32'(hresp_s[0]), 32'd1);
    check("error c1 HREADY_S0", 32'(hready_s[0]), 32'd0);
    check("error c1 HREADY_S1", 32'(hready_s[1]), 32'd0);
    check("error c1 HRESP_S1", 32'(hresp_s[1]), 32'd0);
    check("error c1 HSEL_M", 32'(hsel_m), 32'd0);
    advance();
    slv(1'b1, 2'b01, 32'h0);
    settle();
    check("error c2 HRESP_S0", 32'(hresp_s[0]), 32'd1);
    check("error c2 HREADY_S0", 32'(hready_s[0]), 32'd1);
    check("error c2 S1 issue HSEL_M", 32'(hsel_m), 32'd1);
    check("error c2 S1 issue HADDR_M", haddr_m, 32'h400);
    check("error c2 HRESP_S1", 32'(hresp_s[1]), 32'd0);
    advance();
    slv(1'b1, 2'b00, 32'h5555_0400);
    settle();
    check("error S1 HRDATA_S1", hrdata_s[1], 32'h5555_0400);
    check("error S1 HRESP_S1", 32'(hresp_s[1]), 32'd0);
    advance();

    phase = "midreset";
    drv(0, 2'b10, 32'h500, 1'b0, 0);
    drv(1, 2'b10, 32'h600, 1'b0, 0);
    slv(1'b1, 2'b00, 32'h0);
    settle();
    advance();
    drv(0, 2'b00, 0, 0, 0);
    drv(1, 2'b00, 0, 0, 0);
    slv(1'b0, 2'b00, 32'hCAFE_F00D);
    settle();
    check("midreset before HREADY_S1", 32'(hready_s[1]), 32'd0);
    rst_n = 1'b0;
    model_reset();
    settle();
    check("midreset HREADY_S0", 32'(hready_s[0]), 32'd1);
    check("midreset HREADY_S1", 32'(hready_s[1]), 32'd1);
    check("midreset HTRANS_M", 32'(htrans_m), 32'd0);
    check("midreset HSEL_M", 32'(hsel_m), 32'd0);
    check("midreset HRDATA_S0", hrdata_s[0], 32'd0);
    check("midreset HRDATA_S1", hrdata_s[1], 32'd0);
    advance();
    settle();
    advance();
    rst_n = 1'b1;

    phase = "random";
    held[0] = 1'b0;
    held[1] = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (!rst_n) model_reset();
      rand_masters();
      slv(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0) ? 2'b01 : 2'b00, $urandom);
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
